hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
- Central hazard scheduler for the 5-stage pipeline with branch prediction.
- Generates the forwarding selects consumed by the Execute-stage operand muxes: forward_A_E and forward_B_E.
- Generates stall and flush enables for the IF/ID, ID/EX and EX/MEM pipeline registers.
- Sequences load-use bubbles, branch-mispredict flushes, data-memory wait freezes and the post-reset flush window through a small registered FSM.

Parameters:
- REG_AW, 5, register address width.
- RST_FLUSH_CYC, 2, number of cycles D/E are flushed after reset deasserts (≥1).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- rs1_addr_D  in  REG_AW  Decode source 1
- rs2_addr_D  in  REG_AW  Decode source 2
- rs1_addr_E  in  REG_AW  Execute source 1
- rs2_addr_E  in  REG_AW  Execute source 2
- rd_addr_E  in  REG_AW  Execute destination
- rd_addr_M  in  REG_AW  Memory destination
- rd_addr_W  in  REG_AW  Writeback destination
- mem_rd_E  in  1  instruction in E is a load
- reg_wr_en_M  in  1  M writes the register file
- reg_wr_en_W  in  1  W writes the register file
- mispredict_E  in  1  branch/jump resolved in E disagrees with prediction
- lsu_busy_M  in  1  data memory not ready; M must hold
- forward_A_E  out  2  operand A select: 10=M, 01=W, 00=register file
- forward_B_E  out  2  operand B select, same encoding
- stall_F  out  1  hold PC
- stall_D  out  1  hold IF/ID
- stall_E  out  1  hold ID/EX
- stall_M  out  1  hold EX/MEM
- flush_D  out  1  clear IF/ID to NOP
- flush_E  out  1  clear ID/EX to NOP

Behaviour:
- Forwarding is combinational, evaluated independently for A and B (shown for A):
  - 10 if reg_wr_en_M and rd_addr_M == rs1_addr_E and rd_addr_M != 0.
  - Otherwise 01 if reg_wr_en_W and rd_addr_W == rs1_addr_E and rd_addr_W != 0.
  - Otherwise 00.
  - M has priority over W. Register x0 is never forwarded.
- Load-use hazard (lu):
  - lu = mem_rd_E and rd_addr_E != 0 and (rd_addr_E == rs1_addr_D or rd_addr_E == rs2_addr_D).
- FSM states, registered on clk_i:
  - RST_FLUSH:
    - Entered on reset; a counter loads RST_FLUSH_CYC-1.
    - flush_D=flush_E=1, all stalls 0.
    - Counter decrements each cycle; go to RUN when it is 0.
  - RUN:
    - If lsu_busy_M: go to MEM_WAIT. stall_F/D/E/M=1 in the same cycle, no flushes.
    - Else if mispredict_E: flush_D=flush_E=1, stalls 0.
    - Else if lu: stall_F=stall_D=1, flush_E=1 for that single cycle.
    - Else all outputs 0.
  - MEM_WAIT:
    - stall_F/D/E/M=1, flushes 0.
    - If mispredict_E is seen while waiting, set pend_flush.
    - When lsu_busy_M falls, return to RUN. In that exit cycle stalls are 0, and if pend_flush is set, flush_D=flush_E=1 and pend_flush clears.
- Priority within a cycle: reset > lsu_busy_M > mispredict/pend_flush > load-use.
  - Mispredict coincident with lu: flush only, no stall (the D instruction is wrong-path).
- Reset:
  - Values during rst_i=1: state=RST_FLUSH, pend_flush=0, flush_D=flush_E=1, stalls 0.
  - Forward selects stay combinational (unaffected).
  - Reset mid-MEM_WAIT discards pend_flush.
- Latency:
  - Control outputs are combinational from the current state and inputs; no input-to-output register delay.
  - State changes take effect the next cycle.

Optional Feature:
- Macro HAZARD_PERF_EN.
- Defined:
  - Adds outputs perf_stall_cnt_o[31:0] (cycles with stall_F=1) and perf_flush_cnt_o[31:0] (cycles with flush_E=1 from mispredict only).
  - Both counters clear on rst_i and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package hazard_pkg holds:
  - Typedef fwd_sel_e {FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10}.
  - Typedef hz_state_e {RST_FLUSH, RUN, MEM_WAIT}.
  - The REG_AW default.
- One sub-module, fwd_sel: combinational forward-select for one operand, instantiated twice (A, B).

Test Plan:
- Reset held 3 cycles, then released with RST_FLUSH_CYC=2 → flush_D=flush_E=1 during reset and for exactly 2 cycles after; then all 0.
- rd_addr_M=5, reg_wr_en_M=1, rd_addr_W=5, reg_wr_en_W=1, rs1_addr_E=5 → forward_A_E=10. Same with rd_addr_M=0 → 01. rs2_addr_E=0 with W writing x0 → forward_B_E=00.
- mem_rd_E=1, rd_addr_E=7, rs2_addr_D=7 → one cycle of stall_F=stall_D=flush_E=1. Next cycle, with the load in M, forward_B_E=10 and no stall.
- Load-use plus mispredict_E=1 in the same cycle → flush_D=flush_E=1, stall_F=stall_D=0.
- lsu_busy_M high 4 cycles, with mispredict_E pulsed in wait cycle 2:
  - All four stalls are 1 for 4 cycles, no flush.
  - Exit cycle: stalls 0, flush_D=flush_E=1.
  - Following cycle: flushes 0.
- rst_i asserted in MEM_WAIT with pend_flush set → next cycles show RST_FLUSH behaviour; no extra flush after the reset window; (HAZARD_PERF_EN) counters read 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and defaults for the pipeline hazard controller
package hazard_pkg;

  // Default register address width (32 architectural registers).
  localparam int REG_AW_DEF = 5;

  // Execute-stage operand source select.
  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_e;

  // Hazard sequencer states.
  typedef enum logic [1:0] {
    RST_FLUSH = 2'b00,
    RUN       = 2'b01,
    MEM_WAIT  = 2'b10
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// rtl/hazard_ctrl_fwd_sel.sv - forward-select for one Execute operand (M beats W, x0 never forwarded)
module fwd_sel
  import hazard_pkg::*;
#(
  parameter int AW = REG_AW_DEF
) (
  input  logic [AW-1:0] rs_addr,
  input  logic [AW-1:0] rd_addr_m,
  input  logic          wr_en_m,
  input  logic [AW-1:0] rd_addr_w,
  input  logic          wr_en_w,
  output fwd_sel_e      sel
);

  // Youngest producer wins; a write to x0 has no architectural effect.
  always_comb begin
    sel = FWD_RF;
    if (wr_en_m && (rd_addr_m == rs_addr) && (rd_addr_m != '0)) begin
      sel = FWD_M;
    end else if (wr_en_w && (rd_addr_w == rs_addr) && (rd_addr_w != '0)) begin
      sel = FWD_W;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard scheduler: forwarding, stalls, flushes; HAZARD_PERF_EN adds perf counters
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW        = REG_AW_DEF,
  parameter int RST_FLUSH_CYC = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [REG_AW-1:0] rs1_addr_D,
  input  logic [REG_AW-1:0] rs2_addr_D,
  input  logic [REG_AW-1:0] rs1_addr_E,
  input  logic [REG_AW-1:0] rs2_addr_E,
  input  logic [REG_AW-1:0] rd_addr_E,
  input  logic [REG_AW-1:0] rd_addr_M,
  input  logic [REG_AW-1:0] rd_addr_W,
  input  logic              mem_rd_E,
  input  logic              reg_wr_en_M,
  input  logic              reg_wr_en_W,
  input  logic              mispredict_E,
  input  logic              lsu_busy_M,
  output logic [1:0]        forward_A_E,
  output logic [1:0]        forward_B_E,
  output logic              stall_F,
  output logic              stall_D,
  output logic              stall_E,
  output logic              stall_M,
`ifdef HAZARD_PERF_EN
  output logic [31:0]       perf_stall_cnt_o,
  output logic [31:0]       perf_flush_cnt_o,
`endif
  output logic              flush_D,
  output logic              flush_E
);

  localparam int CNT_W = (RST_FLUSH_CYC > 1) ? $clog2(RST_FLUSH_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(RST_FLUSH_CYC - 1);

  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;

  hz_state_e        state;
  hz_state_e        state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pend_flush;
  logic             pend_nxt;

  logic             lu;
  logic             stall_all;
  logic             stall_fd;
  logic             fl_d;
  logic             fl_e;

  fwd_sel #(.AW(REG_AW)) u_fwd_a (
    .rs_addr   (rs1_addr_E),
    .rd_addr_m (rd_addr_M),
    .wr_en_m   (reg_wr_en_M),
    .rd_addr_w (rd_addr_W),
    .wr_en_w   (reg_wr_en_W),
    .sel       (fwd_a)
  );

  fwd_sel #(.AW(REG_AW)) u_fwd_b (
    .rs_addr   (rs2_addr_E),
    .rd_addr_m (rd_addr_M),
    .wr_en_m   (reg_wr_en_M),
    .rd_addr_w (rd_addr_W),
    .wr_en_w   (reg_wr_en_W),
    .sel       (fwd_b)
  );

  assign forward_A_E = fwd_a;
  assign forward_B_E = fwd_b;

  // A load in E whose result the D instruction needs cannot be forwarded in time.
  assign lu = mem_rd_E && (rd_addr_E != '0) &&
              ((rd_addr_E == rs1_addr_D) || (rd_addr_E == rs2_addr_D));

  // State, reset-window counter and deferred mispredict flag.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= RST_FLUSH;
      cnt        <= CNT_INIT;
      pend_flush <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      pend_flush <= pend_nxt;
    end
  end

  // Next state and control outputs; busy memory outranks redirects, redirects outrank load-use.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pend_nxt  = pend_flush;
    stall_all = 1'b0;
    stall_fd  = 1'b0;
    fl_d      = 1'b0;
    fl_e      = 1'b0;
    if (rst_i) begin
      fl_d = 1'b1;
      fl_e = 1'b1;
    end else begin
      case (state)
        RST_FLUSH: begin
          fl_d = 1'b1;
          fl_e = 1'b1;
          if (cnt == '0) begin
            state_nxt = RUN;
          end else begin
            cnt_nxt = cnt - CNT_W'(1);
          end
        end
        RUN, MEM_WAIT: begin
          if (lsu_busy_M) begin
            // Whole pipe freezes; a redirect seen now is replayed on exit.
            stall_all = 1'b1;
            state_nxt = MEM_WAIT;
            if (mispredict_E) begin
              pend_nxt = 1'b1;
            end
          end else begin
            state_nxt = RUN;
            pend_nxt  = 1'b0;
            if (mispredict_E || pend_flush) begin
              // D is wrong-path, so a coincident load-use is irrelevant.
              fl_d = 1'b1;
              fl_e = 1'b1;
            end else if (lu) begin
              stall_fd = 1'b1;
              fl_e     = 1'b1;
            end
          end
        end
        default: begin
          state_nxt = RST_FLUSH;
          cnt_nxt   = CNT_INIT;
          pend_nxt  = 1'b0;
        end
      endcase
    end
  end

  assign stall_F = stall_all | stall_fd;
  assign stall_D = stall_all | stall_fd;
  assign stall_E = stall_all;
  assign stall_M = stall_all;
  assign flush_D = fl_d;
  assign flush_E = fl_e;

`ifdef HAZARD_PERF_EN
  logic mp_flush;

  assign mp_flush = !rst_i && ((state == RUN) || (state == MEM_WAIT)) &&
                    !lsu_busy_M && (mispredict_E || pend_flush);

  // Saturating event counters for stall cycles and mispredict-driven flushes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_stall_cnt_o <= '0;
      perf_flush_cnt_o <= '0;
    end else begin
      if (stall_F && (perf_stall_cnt_o != 32'hFFFF_FFFF)) begin
        perf_stall_cnt_o <= perf_stall_cnt_o + 32'd1;
      end
      if (mp_flush && (perf_flush_cnt_o != 32'hFFFF_FFFF)) begin
        perf_flush_cnt_o <= perf_flush_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl with directed vectors
module tb_hazard_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [4:0] rs1_addr_D, rs2_addr_D, rs1_addr_E, rs2_addr_E;
  logic [4:0] rd_addr_E, rd_addr_M, rd_addr_W;
  logic       mem_rd_E, reg_wr_en_M, reg_wr_en_W, mispredict_E, lsu_busy_M;
  logic [1:0] forward_A_E, forward_B_E;
  logic       stall_F, stall_D, stall_E, stall_M, flush_D, flush_E;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_stall_cnt_o, perf_flush_cnt_o;
`endif

  int errors = 0;
  int checks = 0;

  // {fwdA, fwdB, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E}
  localparam logic [9:0] IDLE   = 10'b00_00_0000_00;
  localparam logic [9:0] FLUSH  = 10'b00_00_0000_11;
  localparam logic [9:0] STALL4 = 10'b00_00_1111_00;
  localparam logic [9:0] LUSE   = 10'b00_00_1100_01;

  typedef struct {
    string      name;
    logic [9:0] exp;
  } exp_t;

  exp_t sb[$];

  hazard_ctrl #(.REG_AW(5), .RST_FLUSH_CYC(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rs1_addr_D   (rs1_addr_D),
    .rs2_addr_D   (rs2_addr_D),
    .rs1_addr_E   (rs1_addr_E),
    .rs2_addr_E   (rs2_addr_E),
    .rd_addr_E    (rd_addr_E),
    .rd_addr_M    (rd_addr_M),
    .rd_addr_W    (rd_addr_W),
    .mem_rd_E     (mem_rd_E),
    .reg_wr_en_M  (reg_wr_en_M),
    .reg_wr_en_W  (reg_wr_en_W),
    .mispredict_E (mispredict_E),
    .lsu_busy_M   (lsu_busy_M),
    .forward_A_E  (forward_A_E),
    .forward_B_E  (forward_B_E),
    .stall_F      (stall_F),
    .stall_D      (stall_D),
    .stall_E      (stall_E),
    .stall_M      (stall_M),
`ifdef HAZARD_PERF_EN
    .perf_stall_cnt_o (perf_stall_cnt_o),
    .perf_flush_cnt_o (perf_flush_cnt_o),
`endif
    .flush_D      (flush_D),
    .flush_E      (flush_E)
  );

  always #5 clk_i = ~clk_i;

  // Monitor: outputs are valid every cycle; compare mid-cycle against the oldest expectation.
  always @(negedge clk_i) begin
    if (sb.size() > 0) begin
      exp_t t;
      logic [9:0] act;
      t   = sb.pop_front();
      act = {forward_A_E, forward_B_E, stall_F, stall_D, stall_E, stall_M, flush_D, flush_E};
      checks++;
      if (act !== t.exp) begin
        errors++;
        $display("FAIL %s: got %b expected %b (fA fB sF sD sE sM fD fE)", t.name, act, t.exp);
      end
    end
  end

  task automatic clr_in();
    rs1_addr_D = 0; rs2_addr_D = 0; rs1_addr_E = 0; rs2_addr_E = 0;
    rd_addr_E = 0; rd_addr_M = 0; rd_addr_W = 0;
    mem_rd_E = 0; reg_wr_en_M = 0; reg_wr_en_W = 0;
    mispredict_E = 0; lsu_busy_M = 0;
  endtask

  // Queue the expected response for the inputs just applied, then advance one cycle.
  task automatic cyc(input string nm, input logic [9:0] e);
    exp_t t;
    t.name = nm;
    t.exp  = e;
    sb.push_back(t);
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_i = 1'b1;
    clr_in();
    @(posedge clk_i);
    #1;

    // Reset and post-reset flush window.
    repeat (3) cyc("rst_hold", FLUSH);
    rst_i = 1'b0;
    cyc("rst_win1", FLUSH);
    cyc("rst_win2", FLUSH);
    cyc("run_idle", IDLE);

    // Forwarding.
    rd_addr_M = 5; reg_wr_en_M = 1; rd_addr_W = 5; reg_wr_en_W = 1; rs1_addr_E = 5;
    cyc("fwd_m_pri", 10'b10_00_0000_00);
    rd_addr_M = 0;
    cyc("fwd_w", 10'b01_00_0000_00);
    rd_addr_W = 0; rs2_addr_E = 0;
    cyc("fwd_x0", IDLE);
    rs1_addr_E = 3; rs2_addr_E = 5; rd_addr_M = 5; reg_wr_en_M = 0; rd_addr_W = 5; reg_wr_en_W = 1;
    cyc("fwd_b_w", 10'b00_01_0000_00);
    clr_in();

    // Load-use bubble, then forward from M.
    mem_rd_E = 1; rd_addr_E = 7; rs2_addr_D = 7;
    cyc("lu", LUSE);
    clr_in();
    rd_addr_M = 7; reg_wr_en_M = 1; rs2_addr_E = 7;
    cyc("lu_fwd", 10'b00_10_0000_00);
    clr_in();
    mem_rd_E = 1; rd_addr_E = 0; rs1_addr_D = 0;
    cyc("lu_x0", IDLE);
    mem_rd_E = 0; rd_addr_E = 9; rs1_addr_D = 9;
    cyc("no_load", IDLE);
    clr_in();

    // Load-use coincident with mispredict: flush only.
    mem_rd_E = 1; rd_addr_E = 7; rs1_addr_D = 7; mispredict_E = 1;
    cyc("lu_mp", FLUSH);
    clr_in();
    cyc("lu_mp_after", IDLE);

    // Memory wait with mispredict deferred to exit.
    lsu_busy_M = 1;
    cyc("mw1", STALL4);
    mispredict_E = 1;
    cyc("mw2", STALL4);
    mispredict_E = 0;
    cyc("mw3", STALL4);
    cyc("mw4", STALL4);
    lsu_busy_M = 0;
    cyc("mw_exit", FLUSH);
    cyc("mw_after", IDLE);

    // Memory wait without redirect exits cleanly.
    lsu_busy_M = 1;
    cyc("mw_nr1", STALL4);
    cyc("mw_nr2", STALL4);
    lsu_busy_M = 0;
    cyc("mw_nr_exit", IDLE);

    // Reset during memory wait drops the pending flush.
    lsu_busy_M = 1;
    cyc("mwr1", STALL4);
    mispredict_E = 1;
    cyc("mwr2", STALL4);
    mispredict_E = 0; rst_i = 1;
    cyc("mwr_rst", FLUSH);
    rst_i = 0; lsu_busy_M = 0;
    cyc("mwr_win1", FLUSH);
    cyc("mwr_win2", FLUSH);
    cyc("mwr_no_extra", IDLE);
    cyc("mwr_idle", IDLE);

    n = 0;
    while (sb.size() > 0 && n < 10) begin
      @(negedge clk_i);
      n++;
    end
    if (sb.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end

`ifdef HAZARD_PERF_EN
    checks++;
    if (perf_stall_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL perf_stall: got %0d expected 0", perf_stall_cnt_o);
    end
    checks++;
    if (perf_flush_cnt_o !== 32'd0) begin
      errors++;
      $display("FAIL perf_flush: got %0d expected 0", perf_flush_cnt_o);
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
